// File: rtl/spi_reg_file.sv
// spi_reg_file: read-write byte register file behind the SPI slave.
//
// Two writers share a single write port. An SPI write always commits on the
// edge it is sampled. A core write that collides with an SPI write is parked
// in a one-entry pending buffer. That entry commits on the first edge without
// an SPI write, or is discarded if SPI writes the same register first.
// Any address >= RW_REG_COUNT is ignored for both sources.
//
// Optional feature: define SPI_REG_DIRTY_EN to add per-register "written by
// SPI" flags (spi_dirty) with per-register clear strobes (dirty_clr).
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   spi_write           single-cycle SPI write strobe
//   spi_address         SPI target register
//   spi_data            SPI write byte
//   core_write          core write request, accepted only while core_ready=1
//   core_address        core target register
//   core_data           core write byte
//   core_ready          pending buffer empty
//   core_overrun        sticky: a core write arrived while core_ready=0
//   rw_data             flattened register contents, byte i at [8*i+7:8*i]
//   spi_dirty           per-register SPI-written flags  (SPI_REG_DIRTY_EN)
//   dirty_clr           per-register dirty-clear strobes (SPI_REG_DIRTY_EN)
module spi_reg_file #(
    parameter int unsigned                RW_REG_COUNT = 23,
    parameter logic [RW_REG_COUNT*8-1:0]  RESET_VALUE  = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spi_write,
    input  logic [4:0]                spi_address,
    input  logic [7:0]                spi_data,
    input  logic                      core_write,
    input  logic [4:0]                core_address,
    input  logic [7:0]                core_data,
    output logic                      core_ready,
    output logic                      core_overrun,
    output logic [RW_REG_COUNT*8-1:0] rw_data
`ifdef SPI_REG_DIRTY_EN
    ,
    output logic [RW_REG_COUNT-1:0]   spi_dirty,
    input  logic [RW_REG_COUNT-1:0]   dirty_clr
`endif
);

    logic                      pend_valid_q, pend_valid_d;
    logic [4:0]                pend_addr_q, pend_addr_d;
    logic [7:0]                pend_data_q, pend_data_d;
    logic                      core_overrun_q, core_overrun_d;
    logic [RW_REG_COUNT*8-1:0] rw_data_q, rw_data_d;

    logic       spi_in_range;
    logic       core_in_range;
    logic       core_accept;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;

    assign spi_in_range  = {27'd0, spi_address} < RW_REG_COUNT;
    assign core_in_range = {27'd0, core_address} < RW_REG_COUNT;
    assign core_accept   = core_write & ~pend_valid_q;

    always_comb begin
        pend_valid_d   = pend_valid_q;
        pend_addr_d    = pend_addr_q;
        pend_data_d    = pend_data_q;
        core_overrun_d = core_overrun_q | (core_write & pend_valid_q);
        wr_en          = 1'b0;
        wr_addr        = spi_address;
        wr_data        = spi_data;

        if (spi_write) begin
            wr_en = spi_in_range;
            if (pend_valid_q && (pend_addr_q == spi_address)) begin
                // SPI overwrote the parked register: its value is final.
                pend_valid_d = 1'b0;
            end else if (core_accept && core_in_range && (core_address != spi_address)) begin
                // Collision: park the core write. A same-address collision is
                // simply lost to the SPI value.
                pend_valid_d = 1'b1;
                pend_addr_d  = core_address;
                pend_data_d  = core_data;
            end
        end else if (pend_valid_q) begin
            wr_en        = 1'b1;
            wr_addr      = pend_addr_q;
            wr_data      = pend_data_q;
            pend_valid_d = 1'b0;
        end else if (core_accept) begin
            wr_en   = core_in_range;
            wr_addr = core_address;
            wr_data = core_data;
        end

        rw_data_d = rw_data_q;
        for (int i = 0; i < RW_REG_COUNT; i++) begin
            if (wr_en && (wr_addr == 5'(i))) begin
                rw_data_d[8*i +: 8] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q   <= 1'b0;
            pend_addr_q    <= '0;
            pend_data_q    <= '0;
            core_overrun_q <= 1'b0;
            rw_data_q      <= RESET_VALUE;
        end else begin
            pend_valid_q   <= pend_valid_d;
            pend_addr_q    <= pend_addr_d;
            pend_data_q    <= pend_data_d;
            core_overrun_q <= core_overrun_d;
            rw_data_q      <= rw_data_d;
        end
    end

    assign core_ready   = ~pend_valid_q;
    assign core_overrun = core_overrun_q;
    assign rw_data      = rw_data_q;

`ifdef SPI_REG_DIRTY_EN
    logic [RW_REG_COUNT-1:0] dirty_q, dirty_d;

    // Clear first, then set, so a committed SPI write wins over a clear.
    always_comb begin
        dirty_d = dirty_q & ~dirty_clr;
        for (int i = 0; i < RW_REG_COUNT; i++) begin
            if (spi_write && spi_in_range && (spi_address == 5'(i))) begin
                dirty_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_q <= '0;
        end else begin
            dirty_q <= dirty_d;
        end
    end

    assign spi_dirty = dirty_q;
`endif

endmodule

// File: tb/tb_spi_reg_file.sv
// Self-checking bench for spi_reg_file: directed cases plus randomized traffic,
// checked every cycle against a queue-based reference model via a scoreboard.
module tb_spi_reg_file;

    localparam int unsigned N = 23;
    localparam logic [N*8-1:0] RV = {{(N*8-32){1'b0}}, 32'hA500_5A00};

    logic           clk;
    logic           rst_n;
    logic           spi_write;
    logic [4:0]     spi_address;
    logic [7:0]     spi_data;
    logic           core_write;
    logic [4:0]     core_address;
    logic [7:0]     core_data;
    logic           core_ready;
    logic           core_overrun;
    logic [N*8-1:0] rw_data;
    logic [N-1:0]   dirty_clr;
    logic [N-1:0]   dirty_obs;

    spi_reg_file #(
        .RW_REG_COUNT (N),
        .RESET_VALUE  (RV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_write    (spi_write),
        .spi_address  (spi_address),
        .spi_data     (spi_data),
        .core_write   (core_write),
        .core_address (core_address),
        .core_data    (core_data),
        .core_ready   (core_ready),
        .core_overrun (core_overrun),
        .rw_data      (rw_data)
`ifdef SPI_REG_DIRTY_EN
        ,
        .spi_dirty    (dirty_obs),
        .dirty_clr    (dirty_clr)
`endif
    );

`ifndef SPI_REG_DIRTY_EN
    assign dirty_obs = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } pend_t;

    typedef struct packed {
        logic [N*8-1:0] rw;
        logic           ready;
        logic           ovr;
        logic [N-1:0]   dirty;
    } exp_t;

    logic [7:0]   m_regs [N];
    pend_t        m_pend [$];
    logic         m_ovr;
    logic [N-1:0] m_dirty;
    exp_t         exp_q [$];

    int checks   = 0;
    int failures = 0;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = RV[8*i +: 8];
        m_pend.delete();
        m_ovr   = 1'b0;
        m_dirty = '0;
    endfunction

    function automatic void model_edge(input logic sw, input logic [4:0] sa,
                                       input logic [7:0] sd, input logic cw,
                                       input logic [4:0] ca, input logic [7:0] cd,
                                       input logic [N-1:0] clr);
        bit    ready;
        pend_t p;
        ready = (m_pend.size() == 0);
        if (cw && !ready) m_ovr = 1'b1;
        m_dirty = m_dirty & ~clr;
        if (sw) begin
            if (int'(sa) < N) begin
                m_regs[sa]  = sd;
                m_dirty[sa] = 1'b1;
            end
            if (m_pend.size() > 0 && m_pend[0].addr == sa) m_pend.delete();
            if (cw && ready && int'(ca) < N && ca != sa) begin
                p.addr = ca;
                p.data = cd;
                m_pend.push_back(p);
            end
        end else if (m_pend.size() > 0) begin
            p = m_pend.pop_front();
            m_regs[p.addr] = p.data;
        end else if (cw && int'(ca) < N) begin
            m_regs[ca] = cd;
        end
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        for (int i = 0; i < N; i++) e.rw[8*i +: 8] = m_regs[i];
        e.ready = (m_pend.size() == 0);
        e.ovr   = m_ovr;
        e.dirty = m_dirty;
        return e;
    endfunction

    task automatic chk(input string name, input logic [N*8-1:0] act,
                       input logic [N*8-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_rw_data", rw_data, e.rw);
            chk("sb_core_ready", {{(N*8-1){1'b0}}, core_ready}, {{(N*8-1){1'b0}}, e.ready});
            chk("sb_core_overrun", {{(N*8-1){1'b0}}, core_overrun}, {{(N*8-1){1'b0}}, e.ovr});
`ifdef SPI_REG_DIRTY_EN
            chk("sb_spi_dirty", {{(N*7){1'b0}}, dirty_obs}, {{(N*7){1'b0}}, e.dirty});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic sw, input logic [4:0] sa, input logic [7:0] sd,
                        input logic cw, input logic [4:0] ca, input logic [7:0] cd,
                        input logic [N-1:0] clr);
        spi_write    = sw;
        spi_address  = sa;
        spi_data     = sd;
        core_write   = cw;
        core_address = ca;
        core_data    = cd;
        dirty_clr    = clr;
        @(posedge clk);
        model_edge(sw, sa, sd, cw, ca, cd, clr);
        exp_q.push_back(model_exp());
        #1;
        spi_write  = 1'b0;
        core_write = 1'b0;
        dirty_clr  = '0;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0, '0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_rw_data", rw_data, RV);
        chk("async_rst_core_ready", {{(N*8-1){1'b0}}, core_ready}, {{(N*8-1){1'b0}}, 1'b1});
        chk("async_rst_core_overrun", {{(N*8-1){1'b0}}, core_overrun}, '0);
        chk("async_rst_spi_dirty", {{(N*7){1'b0}}, dirty_obs}, '0);
        exp_q.push_back(model_exp());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [N*8-1:0] snap;
    logic [N-1:0]   clr6;

    initial begin
        rst_n        = 1'b0;
        spi_write    = 1'b0;
        spi_address  = '0;
        spi_data     = '0;
        core_write   = 1'b0;
        core_address = '0;
        core_data    = '0;
        dirty_clr    = '0;
        clr6         = '0;
        clr6[6]      = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values
        chk("reset_byte3", {{(N*8-8){1'b0}}, rw_data[31:24]}, {{(N*8-8){1'b0}}, 8'hA5});
        chk("reset_core_ready", {{(N*8-1){1'b0}}, core_ready}, {{(N*8-1){1'b0}}, 1'b1});
        chk("reset_core_overrun", {{(N*8-1){1'b0}}, core_overrun}, '0);

        // Basic writes
        step(1'b1, 5'd2, 8'h3C, 1'b0, 5'd0, 8'h00, '0);
        chk("spi_wr_reg2", {{(N*8-8){1'b0}}, rw_data[23:16]}, {{(N*8-8){1'b0}}, 8'h3C});
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd5, 8'h77, '0);
        chk("core_wr_reg5", {{(N*8-8){1'b0}}, rw_data[47:40]}, {{(N*8-8){1'b0}}, 8'h77});

        // Out-of-range address
        snap = rw_data;
        step(1'b1, 5'd23, 8'hFF, 1'b0, 5'd0, 8'h00, '0);
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd23, 8'hEE, '0);
        chk("out_of_range_no_change", rw_data, snap);

        // Collision, different addresses
        step(1'b1, 5'd1, 8'h11, 1'b1, 5'd4, 8'h22, '0);
        chk("coll_reg1", {{(N*8-8){1'b0}}, rw_data[15:8]}, {{(N*8-8){1'b0}}, 8'h11});
        chk("coll_ready_low", {{(N*8-1){1'b0}}, core_ready}, '0);
        chk("coll_reg4_not_yet", {{(N*8-8){1'b0}}, rw_data[39:32]}, '0);
        idle();
        chk("coll_reg4_commit", {{(N*8-8){1'b0}}, rw_data[39:32]}, {{(N*8-8){1'b0}}, 8'h22});
        chk("coll_ready_high", {{(N*8-1){1'b0}}, core_ready}, {{(N*8-1){1'b0}}, 1'b1});

        // Collision followed by an SPI burst
        step(1'b1, 5'd7, 8'hAA, 1'b1, 5'd4, 8'h33, '0);
        step(1'b1, 5'd8, 8'hBB, 1'b0, 5'd0, 8'h00, '0);
        step(1'b1, 5'd9, 8'hCC, 1'b0, 5'd0, 8'h00, '0);
        chk("burst_reg4_held", {{(N*8-8){1'b0}}, rw_data[39:32]}, {{(N*8-8){1'b0}}, 8'h22});
        chk("burst_ready_low", {{(N*8-1){1'b0}}, core_ready}, '0);
        idle();
        chk("burst_reg4_commit", {{(N*8-8){1'b0}}, rw_data[39:32]}, {{(N*8-8){1'b0}}, 8'h33});

        // SPI overwrite discards the pending entry
        step(1'b1, 5'd10, 8'h01, 1'b1, 5'd4, 8'h44, '0);
        step(1'b1, 5'd4, 8'h99, 1'b0, 5'd0, 8'h00, '0);
        chk("ovw_reg4", {{(N*8-8){1'b0}}, rw_data[39:32]}, {{(N*8-8){1'b0}}, 8'h99});
        chk("ovw_ready", {{(N*8-1){1'b0}}, core_ready}, {{(N*8-1){1'b0}}, 1'b1});
        idle();
        chk("ovw_reg4_final", {{(N*8-8){1'b0}}, rw_data[39:32]}, {{(N*8-8){1'b0}}, 8'h99});

        // Overrun
        step(1'b1, 5'd11, 8'h05, 1'b1, 5'd12, 8'h66, '0);
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd13, 8'hDD, '0);
        chk("ovr_set", {{(N*8-1){1'b0}}, core_overrun}, {{(N*8-1){1'b0}}, 1'b1});
        chk("ovr_pending_reg12", {{(N*8-8){1'b0}}, rw_data[103:96]}, {{(N*8-8){1'b0}}, 8'h66});
        idle();
        chk("ovr_reg13_unchanged", {{(N*8-8){1'b0}}, rw_data[111:104]}, '0);
        chk("ovr_sticky", {{(N*8-1){1'b0}}, core_overrun}, {{(N*8-1){1'b0}}, 1'b1});

        // Dirty flags
        step(1'b1, 5'd6, 8'h01, 1'b0, 5'd0, 8'h00, '0);
`ifdef SPI_REG_DIRTY_EN
        chk("dirty6_set", {{(N*8-1){1'b0}}, dirty_obs[6]}, {{(N*8-1){1'b0}}, 1'b1});
`endif
        step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, clr6);
`ifdef SPI_REG_DIRTY_EN
        chk("dirty6_clr", {{(N*8-1){1'b0}}, dirty_obs[6]}, '0);
`endif
        step(1'b1, 5'd6, 8'h02, 1'b0, 5'd0, 8'h00, clr6);
`ifdef SPI_REG_DIRTY_EN
        chk("dirty6_set_wins", {{(N*8-1){1'b0}}, dirty_obs[6]}, {{(N*8-1){1'b0}}, 1'b1});
`endif
        step(1'b0, 5'd0, 8'h00, 1'b1, 5'd6, 8'h55, '0);
        chk("core_wr_reg6", {{(N*8-8){1'b0}}, rw_data[55:48]}, {{(N*8-8){1'b0}}, 8'h55});
`ifdef SPI_REG_DIRTY_EN
        chk("dirty6_core_untouched", {{(N*8-1){1'b0}}, dirty_obs[6]}, {{(N*8-1){1'b0}}, 1'b1});
`endif

        // Reset clears overrun
        do_reset();
        chk("post_reset_overrun", {{(N*8-1){1'b0}}, core_overrun}, '0);

        // Randomized traffic, with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] rclr;
            rclr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            if (i == 200) do_reset();
            step(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 24)), 8'($urandom),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 24)), 8'($urandom),
                 rclr);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", {{(N*8-32){1'b0}}, 32'(exp_q.size())}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_reg_file.md
# spi_reg_file

Register file directly downstream of the SPI slave. It holds the `RW_REG_COUNT` read-write bytes and commits the slave's single-cycle write strobes into them. It also accepts writes from on-chip core logic, with SPI taking priority and a one-entry pending buffer absorbing collisions. The flattened `rw_data` output feeds back to the SPI slave for readback and out to the design.

## Interface
Parameters:
- `RW_REG_COUNT`, 23: number of read-write byte registers (max 32, addressed by 5 bits).
- `RESET_VALUE`, {RW_REG_COUNT*8{1'b0}}: flattened per-register reset contents; byte i is `[8*i+7:8*i]`.

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `spi_write`  in  1: single-cycle write strobe from the SPI slave.
- `spi_address`  in  5: SPI target register.
- `spi_data`  in  8: SPI write byte.
- `core_write`  in  1: core write request; honoured only while `core_ready`=1.
- `core_address`  in  5: core target register.
- `core_data`  in  8: core write byte.
- `core_ready`  out  1: pending buffer empty; a core write is accepted this cycle.
- `core_overrun`  out  1: sticky; a core write arrived while `core_ready`=0.
- `rw_data`  out  RW_REG_COUNT*8: flattened register contents.
- `spi_dirty`  out  RW_REG_COUNT: per-register "written by SPI" flags (only with `SPI_REG_DIRTY_EN`).
- `dirty_clr`  in  RW_REG_COUNT: per-register dirty-clear strobes (only with `SPI_REG_DIRTY_EN`).

## Operation
- All state is held in flops on posedge `clk`, with asynchronous clear on `rst_n`=0.
- Reset values:
  - `rw_data`=`RESET_VALUE`.
  - Pending buffer empty, so `core_ready`=1.
  - `core_overrun`=0.
  - `spi_dirty`=0.
- Address check: an address >= `RW_REG_COUNT` is ignored for both sources. There is no wrap and no aliasing.
- Each edge, the write port resolves in this priority order:
  1. `spi_write`=1: commit `spi_data` to `spi_address`.
  2. Otherwise, pending buffer valid: commit the pending entry and empty the buffer.
  3. Otherwise, `core_write` with `core_ready`=1: commit directly.
- Collision (`spi_write` and an accepted `core_write` on the same edge):
  - SPI commits.
  - The core entry is stored in the pending buffer and `core_ready` drops.
- Pending buffer while SPI writes continue:
  - The buffer holds through any run of back-to-back SPI writes.
  - It commits on the first edge with `spi_write`=0.
- SPI overwrite rule: if an SPI write targets the same address as the pending entry (including on the collision edge), the pending entry is discarded and the buffer empties. The SPI value is final.
- Core write while `core_ready`=0:
  - The write is dropped.
  - `core_overrun` sets and stays set until reset.
- There is no read path; `rw_data` is purely registered.

## Timing
- Write latency is 1 edge: for a strobe sampled at edge N, the new byte is on `rw_data` after edge N.
- Collided core write: committed at the first edge after the SPI burst ends, and visible 1 cycle after that edge.
- `core_ready` is registered: it is low in the cycle following the collision edge and high again the cycle after the pending commit or discard.
- `core_overrun` rises the cycle after the offending edge.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). A pending entry is lost.

## Configuration
- `SPI_REG_DIRTY_EN` defined: the block provides `spi_dirty` and `dirty_clr`.
  - Bit i sets on a committed SPI write to register i.
  - Bit i clears on a `dirty_clr[i]` pulse.
  - Set wins over clear on the same edge.
  - Core writes never touch the dirty flags.
- `SPI_REG_DIRTY_EN` undefined: both ports are absent and no dirty flops exist. All other behaviour is identical.

## Test plan
- Reset value: assert reset with `RESET_VALUE` byte 3=8'hA5, then release. Required: `rw_data[31:24]`=8'hA5, `core_ready`=1, `core_overrun`=0.
- Basic writes:
  - SPI write 8'h3C to address 2, then core write 8'h77 to address 5 on a later edge. Required: each byte appears the cycle after its edge.
  - Write to address 23 (out of range). Required: no change.
- Collision, different addresses: SPI 8'h11→1 and core 8'h22→4 on the same edge. Required:
  - Reg1=8'h11 after edge N and `core_ready`=0.
  - Reg4=8'h22 after edge N+1 and `core_ready`=1.
- Collision with SPI burst, then SPI overwrite:
  - Collision, then SPI writes on edges N+1 and N+2 to other addresses. Required: reg4 is committed at N+3.
  - Repeat with an SPI write to reg4 (8'h99) at N+1. Required: reg4 ends at 8'h99 and the pending entry is discarded.
- Overrun: core write while `core_ready`=0. Required: `core_overrun`=1 and the register is unchanged. Required after reset: `core_overrun`=0.
- Dirty flags (`SPI_REG_DIRTY_EN`):
  - SPI write to reg 6. Required: `spi_dirty[6]`=1. Pulse `dirty_clr[6]`. Required: bit 6 returns to 0.
  - Assert `dirty_clr[6]` and an SPI write to reg 6 on the same edge. Required: bit 6 stays 1.
  - Core write to reg 6. Required: bit 6 unchanged.
